// File: rtl/pcpu_fetch_queue.sv
// pcpu_fetch_queue
//   Instruction-fetch front end for the pipelined CPU. It issues sequential
//   fetches to a variable-latency instruction memory and keeps up to DEPTH
//   fetches in flight or buffered, in program order. It hands {pc, inst} to
//   the decode stage over a valid/ready handshake. A branch redirect flushes
//   the queue and discards the memory responses that are still in flight.
//
// Ports
//   clk             rising-edge clock
//   rst             asynchronous active-low reset
//   imem_req_*      fetch request (valid/ready, addr)
//   imem_rsp_*      in-order fetch response (valid, data); no back-pressure
//   redirect_*      one-cycle branch/jump redirect pulse with the new PC
//   deq_*           head instruction to decode (valid/ready, pc, inst)
//   occupancy       number of reserved queue entries
//   protocol_err    sticky flag: a response arrived with nothing outstanding
module pcpu_fetch_queue #(
  parameter int unsigned       XLEN       = 32,
  parameter int unsigned       DEPTH      = 4,
  parameter logic [XLEN-1:0]   PC_INITIAL = '0,
  localparam int unsigned      CW         = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            deq_valid,
  output logic [XLEN-1:0] deq_pc,
  output logic [31:0]     deq_inst,
  input  logic            deq_ready,
  output logic [CW-1:0]   occupancy,
  output logic            protocol_err
);

  localparam int unsigned     PW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW:0]     DEPTH_W    = (CW + 1)'(DEPTH);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);
  localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);

  // Queue storage. An entry is reserved at tail on request handshake,
  // filled at fill_ptr on response and freed at head on dequeue.
  logic [XLEN-1:0] pc_mem   [DEPTH];
  logic [31:0]     inst_mem [DEPTH];
  logic [DEPTH-1:0] filled;

  logic [PW-1:0]   tail;
  logic [PW-1:0]   fill_ptr;
  logic [PW-1:0]   head;

  logic [XLEN-1:0] fetch_pc;
  logic [CW-1:0]   occ;
  logic [CW-1:0]   pending;   // reserved entries still waiting for a response
  logic [CW-1:0]   discard;   // stale responses still to be dropped

  logic [CW-1:0]   occ_next;
  logic [CW-1:0]   pending_next;
  logic [CW-1:0]   discard_next;
  logic [CW:0]     level;

  logic            req_fire;
  logic            deq_fire;
  logic            rsp_fill;
  logic            rsp_drop;
  logic            rsp_orphan;

  assign imem_req_addr = fetch_pc;
  assign deq_pc        = pc_mem[head];
  assign deq_inst      = inst_mem[head];
  assign occupancy     = occ;

  always_comb begin
    level          = {1'b0, occ} + {1'b0, discard};
    // Gating with rst keeps the request low for the whole reset interval,
    // not just from the first clock edge.
    imem_req_valid = rst && !redirect_valid && (level < DEPTH_W);
    req_fire       = imem_req_valid && imem_req_ready;

    deq_valid      = filled[head] && !redirect_valid;
    deq_fire       = deq_valid && deq_ready;

    rsp_orphan     = imem_rsp_valid && (discard == '0) && (pending == '0);
    rsp_drop       = imem_rsp_valid && (discard != '0);
    rsp_fill       = imem_rsp_valid && !redirect_valid &&
                     (discard == '0) && (pending != '0);

    occ_next       = occ;
    pending_next   = pending;
    discard_next   = discard;

    if (redirect_valid) begin
      // Every unfilled reservation becomes a stale response. A response
      // arriving right now is one of them (or an old discard) unless it is
      // an orphan, which was never counted anywhere.
      occ_next     = '0;
      pending_next = '0;
      discard_next = discard + pending - CW'(imem_rsp_valid && !rsp_orphan);
    end else begin
      occ_next     = occ + CW'(req_fire) - CW'(deq_fire);
      pending_next = pending + CW'(req_fire) - CW'(rsp_fill);
      discard_next = discard - CW'(rsp_drop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc     <= PC_INITIAL & ALIGN_MASK;
      tail         <= '0;
      fill_ptr     <= '0;
      head         <= '0;
      filled       <= '0;
      occ          <= '0;
      pending      <= '0;
      discard      <= '0;
      protocol_err <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        pc_mem[i]   <= '0;
        inst_mem[i] <= '0;
      end
    end else begin
      occ     <= occ_next;
      pending <= pending_next;
      discard <= discard_next;

      if (rsp_orphan) begin
        protocol_err <= 1'b1;
      end

      if (redirect_valid) begin
        fetch_pc <= redirect_pc & ALIGN_MASK;
        tail     <= '0;
        fill_ptr <= '0;
        head     <= '0;
        filled   <= '0;
      end else begin
        // tail, fill_ptr and head never alias when their enables coincide:
        // reserve needs a free slot, fill an unfilled one, dequeue a filled one.
        if (req_fire) begin
          pc_mem[tail] <= fetch_pc;
          filled[tail] <= 1'b0;
          tail         <= tail + PW'(1);
          fetch_pc     <= fetch_pc + PC_STEP;
        end
        if (rsp_fill) begin
          inst_mem[fill_ptr] <= imem_rsp_data;
          filled[fill_ptr]   <= 1'b1;
          fill_ptr           <= fill_ptr + PW'(1);
        end
        if (deq_fire) begin
          filled[head] <= 1'b0;
          head         <= head + PW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_pcpu_fetch_queue.sv
// Directed testbench for pcpu_fetch_queue (XLEN=32, DEPTH=4, PC_INITIAL=0).
// A small in-order memory model returns ~addr as the instruction after a
// configurable latency; requests and dequeues are logged and compared with
// hand-computed sequences.
module tb_pcpu_fetch_queue;

  localparam int unsigned CW = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        deq_valid;
  logic [31:0] deq_pc;
  logic [31:0] deq_inst;
  logic        deq_ready;
  logic [CW-1:0] occupancy;
  logic        protocol_err;

  always #5 clk = ~clk;

  pcpu_fetch_queue #(
    .XLEN      (32),
    .DEPTH     (4),
    .PC_INITIAL(32'h0)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req_valid(imem_req_valid),
    .imem_req_addr (imem_req_addr),
    .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .deq_valid     (deq_valid),
    .deq_pc        (deq_pc),
    .deq_inst      (deq_inst),
    .deq_ready     (deq_ready),
    .occupancy     (occupancy),
    .protocol_err  (protocol_err)
  );

  typedef struct {
    logic [31:0] addr;
    int unsigned due;
  } mreq_t;

  mreq_t       mq[$];
  logic [31:0] req_log[$];
  logic [31:0] dpc_log[$];
  logic [31:0] dinst_log[$];
  int unsigned cyc = 0;
  int unsigned lat = 1;
  bit          rsp_manual = 1'b0;
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock cycle. Called just after a falling edge with inputs set.
  task automatic cycle();
    logic        rf, rspf, df;
    logic [31:0] ra, dp, di;
    #1;
    rf   = imem_req_valid && imem_req_ready;
    ra   = imem_req_addr;
    rspf = imem_rsp_valid;
    df   = deq_valid && deq_ready;
    dp   = deq_pc;
    di   = deq_inst;
    @(posedge clk);
    cyc++;
    if (rf) begin
      mq.push_back('{addr: ra, due: cyc + lat});
      req_log.push_back(ra);
    end
    if (rspf && !rsp_manual && mq.size() > 0) void'(mq.pop_front());
    if (df) begin
      dpc_log.push_back(dp);
      dinst_log.push_back(di);
    end
    @(negedge clk);
    if (!rsp_manual) begin
      if (mq.size() > 0 && mq[0].due <= cyc + 1) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = ~mq[0].addr;
      end else begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
      end
    end
  endtask

  task automatic do_reset();
    rst            = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    deq_ready      = 1'b0;
    rsp_manual     = 1'b0;
    mq.delete();
    req_log.delete();
    dpc_log.delete();
    dinst_log.delete();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [CW-1:0] omax;
    rst            = 1'b1;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    deq_ready      = 1'b0;
    #1 rst = 1'b0;
    #2;
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("rst_req_addr", imem_req_addr, 32'h0);
    check("rst_deq_valid", 32'(deq_valid), 32'd0);
    check("rst_occupancy", 32'(occupancy), 32'd0);
    check("rst_protocol_err", 32'(protocol_err), 32'd0);
    check("rst_deq_pc", deq_pc, 32'h0);
    check("rst_deq_inst", deq_inst, 32'h0);
    @(negedge clk);

    // 1: streaming, latency 1
    do_reset();
    lat = 1; imem_req_ready = 1'b1; deq_ready = 1'b1;
    cycle(); cycle();
    #1;
    check("t1_first_deq_valid", 32'(deq_valid), 32'd1);
    check("t1_first_deq_pc", deq_pc, 32'h0);
    check("t1_first_deq_inst", deq_inst, 32'hFFFF_FFFF);
    omax = '0;
    for (int i = 0; i < 8; i++) begin
      cycle();
      #1;
      if (occupancy > omax) omax = occupancy;
    end
    check("t1_req_count", 32'(req_log.size()), 32'd10);
    check("t1_deq_count", 32'(dpc_log.size()), 32'd8);
    for (int i = 0; i < 10; i++) check("t1_req_addr", req_log[i], 32'(4 * i));
    for (int i = 0; i < 8; i++) begin
      check("t1_deq_pc", dpc_log[i], 32'(4 * i));
      check("t1_deq_inst", dinst_log[i], ~32'(4 * i));
    end
    check("t1_occ_max", 32'(omax), 32'd2);

    // 2: full queue with decode stalled, then one dequeue and a redirect
    do_reset();
    lat = 1; imem_req_ready = 1'b1; deq_ready = 1'b0;
    repeat (6) cycle();
    #1;
    check("t2_req_count", 32'(req_log.size()), 32'd4);
    for (int i = 0; i < 4; i++) check("t2_req_addr", req_log[i], 32'(4 * i));
    check("t2_full_req_valid", 32'(imem_req_valid), 32'd0);
    check("t2_full_occ", 32'(occupancy), 32'd4);
    check("t2_full_deq_valid", 32'(deq_valid), 32'd1);
    check("t2_full_deq_pc", deq_pc, 32'h0);
    deq_ready = 1'b1;
    cycle();
    deq_ready = 1'b0;
    #1;
    check("t2_deq_count", 32'(dpc_log.size()), 32'd1);
    check("t2_deq_pc0", dpc_log[0], 32'h0);
    check("t2_next_req_valid", 32'(imem_req_valid), 32'd1);
    check("t2_next_req_addr", imem_req_addr, 32'h10);
    check("t2_occ_after_deq", 32'(occupancy), 32'd3);
    check("t2_head_pc", deq_pc, 32'h4);
    redirect_valid = 1'b1; redirect_pc = 32'h40; deq_ready = 1'b1;
    #1;
    check("t2_redir_deq_valid", 32'(deq_valid), 32'd0);
    check("t2_redir_req_valid", 32'(imem_req_valid), 32'd0);
    cycle();
    redirect_valid = 1'b0;
    #1;
    check("t2_flush_occ", 32'(occupancy), 32'd0);
    check("t2_flush_deq_valid", 32'(deq_valid), 32'd0);
    check("t2_flush_req_addr", imem_req_addr, 32'h40);
    check("t2_flush_deq_count", 32'(dpc_log.size()), 32'd1);

    // 3: latency 3, redirect to unaligned PC with two fetches in flight
    do_reset();
    lat = 3; imem_req_ready = 1'b1; deq_ready = 1'b1;
    cycle(); cycle();
    redirect_valid = 1'b1; redirect_pc = 32'h103;
    #1;
    check("t3_redir_req_valid", 32'(imem_req_valid), 32'd0);
    cycle();
    redirect_valid = 1'b0;
    #1;
    check("t3_req_valid", 32'(imem_req_valid), 32'd1);
    check("t3_req_addr", imem_req_addr, 32'h100);
    check("t3_occ", 32'(occupancy), 32'd0);
    repeat (8) cycle();
    #1;
    check("t3_req_count", 32'(req_log.size()), 32'd9);
    check("t3_req2", req_log[2], 32'h100);
    check("t3_req8", req_log[8], 32'h118);
    check("t3_deq_count", 32'(dpc_log.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check("t3_deq_pc", dpc_log[i], 32'h100 + 32'(4 * i));
      check("t3_deq_inst", dinst_log[i], ~(32'h100 + 32'(4 * i)));
    end
    check("t3_protocol_err", 32'(protocol_err), 32'd0);

    // 4: redirect coinciding with a response, three fetches in flight
    do_reset();
    lat = 3; imem_req_ready = 1'b1; deq_ready = 1'b1;
    repeat (3) cycle();
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    #1;
    check("t4_redir_deq_valid", 32'(deq_valid), 32'd0);
    check("t4_redir_req_valid", 32'(imem_req_valid), 32'd0);
    cycle();
    redirect_valid = 1'b0;
    repeat (6) cycle();
    #1;
    check("t4_deq_count", 32'(dpc_log.size()), 32'd2);
    check("t4_deq_pc0", dpc_log[0], 32'h200);
    check("t4_deq_inst0", dinst_log[0], ~32'h200);
    check("t4_deq_pc1", dpc_log[1], 32'h204);
    check("t4_deq_inst1", dinst_log[1], ~32'h204);
    check("t4_occ", 32'(occupancy), 32'd3);
    check("t4_protocol_err", 32'(protocol_err), 32'd0);

    // 5: PC wrap at the top of the address space
    do_reset();
    lat = 1; imem_req_ready = 1'b1; deq_ready = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    cycle();
    redirect_valid = 1'b0;
    #1;
    check("t5_req_addr", imem_req_addr, 32'hFFFF_FFFC);
    repeat (4) cycle();
    #1;
    check("t5_req_count", 32'(req_log.size()), 32'd4);
    check("t5_req0", req_log[0], 32'hFFFF_FFFC);
    check("t5_req1", req_log[1], 32'h0);
    check("t5_req2", req_log[2], 32'h4);
    check("t5_deq_count", 32'(dpc_log.size()), 32'd2);
    check("t5_deq_pc0", dpc_log[0], 32'hFFFF_FFFC);
    check("t5_deq_inst0", dinst_log[0], 32'h3);
    check("t5_deq_pc1", dpc_log[1], 32'h0);

    // 6: orphan response, sticky error, then reset mid-burst
    do_reset();
    imem_req_ready = 1'b0; deq_ready = 1'b1;
    rsp_manual = 1'b1; imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_BEEF;
    cycle();
    imem_rsp_valid = 1'b0; imem_rsp_data = '0; rsp_manual = 1'b0;
    #1;
    check("t6_protocol_err", 32'(protocol_err), 32'd1);
    check("t6_occ", 32'(occupancy), 32'd0);
    check("t6_deq_valid", 32'(deq_valid), 32'd0);
    lat = 1; imem_req_ready = 1'b1;
    repeat (5) cycle();
    #1;
    check("t6_err_sticky", 32'(protocol_err), 32'd1);
    check("t6_burst_occ", 32'(occupancy), 32'd2);
    check("t6_burst_deq_valid", 32'(deq_valid), 32'd1);
    #1 rst = 1'b0;
    #1;
    check("t6_rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("t6_rst_req_addr", imem_req_addr, 32'h0);
    check("t6_rst_deq_valid", 32'(deq_valid), 32'd0);
    check("t6_rst_occ", 32'(occupancy), 32'd0);
    check("t6_rst_protocol_err", 32'(protocol_err), 32'd0);
    check("t6_rst_deq_pc", deq_pc, 32'h0);
    check("t6_rst_deq_inst", deq_inst, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
